// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arithmetic ops plus
// iterative shift-left and shift-add multiply behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock_5,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       ope,
  input  logic [WIDTH-1:0] immidiate_data,
  input  logic [WIDTH-1:0] registor_in,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] alu_result_bus,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h29;
  localparam logic [7:0] OP_CMP  = 8'h39;
  localparam logic [7:0] OP_AND  = 8'h21;
  localparam logic [7:0] OP_OR   = 8'h09;
  localparam logic [7:0] OP_XOR  = 8'h31;
  localparam logic [7:0] OP_INC  = 8'h40;
  localparam logic [7:0] OP_DEC  = 8'h48;
  localparam logic [7:0] OP_PUSH = 8'h55;
  localparam logic [7:0] OP_POP  = 8'h5d;
  localparam logic [7:0] OP_MOV  = 8'h89;
  localparam logic [7:0] OP_SHL  = 8'hd1;
  localparam logic [7:0] OP_MUL  = 8'hf7;

  // The stack pointer moves by one machine word, i.e. WIDTH/8 bytes.
  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(WIDTH / 8);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d;
  logic                 busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;

  logic [WIDTH:0]       ext;
  logic [WIDTH-1:0]     res;
  logic [WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]   prod_nx;
  logic                 upd_zs;

  assign busy           = busy_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign alu_result_bus = result_q;
  assign zf             = zf_q;
  assign sf             = sf_q;
  assign cf             = cf_q;
  assign of             = of_q;

  // State register; reset aborts any iterative op without a done pulse.
  always_ff @(posedge clock_5 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers, all cleared by reset.
  always_ff @(posedge clock_5 or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zf_q      <= 1'b0;
      sf_q      <= 1'b0;
      cf_q      <= 1'b0;
      of_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zf_q      <= zf_d;
      sf_q      <= sf_d;
      cf_q      <= cf_d;
      of_q      <= of_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, operation decode and iteration step; res carries the value
  // that zf/sf are derived from whenever an op writes those flags.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zf_d      = zf_q;
    sf_d      = sf_q;
    cf_d      = cf_q;
    of_d      = of_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    ext       = '0;
    res       = '0;
    addend    = '0;
    prod_nx   = '0;
    upd_zs    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = ope;
          a_d    = registor_in;
          prod_d = {{WIDTH{1'b0}}, immidiate_data};
          cnt_d  = immidiate_data[SHW-1:0];
          case (ope)
            OP_ADD: begin
              ext      = {1'b0, registor_in} + {1'b0, immidiate_data};
              res      = ext[WIDTH-1:0];
              result_d = res;
              cf_d     = ext[WIDTH];
              of_d     = (registor_in[MSB] == immidiate_data[MSB]) && (res[MSB] != registor_in[MSB]);
              upd_zs   = 1'b1;
              done_d   = 1'b1;
            end
            OP_SUB, OP_CMP: begin
              res = registor_in - immidiate_data;
              if (ope == OP_SUB) result_d = res;
              cf_d   = registor_in < immidiate_data;
              of_d   = (registor_in[MSB] != immidiate_data[MSB]) && (res[MSB] != registor_in[MSB]);
              upd_zs = 1'b1;
              done_d = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              if (ope == OP_AND)     res = registor_in & immidiate_data;
              else if (ope == OP_OR) res = registor_in | immidiate_data;
              else                   res = registor_in ^ immidiate_data;
              result_d = res;
              cf_d     = 1'b0;
              of_d     = 1'b0;
              upd_zs   = 1'b1;
              done_d   = 1'b1;
            end
            OP_INC: begin
              res      = registor_in + ONE;
              result_d = res;
              of_d     = ~registor_in[MSB] & res[MSB];
              upd_zs   = 1'b1;
              done_d   = 1'b1;
            end
            OP_DEC: begin
              res      = registor_in - ONE;
              result_d = res;
              of_d     = registor_in[MSB] & ~res[MSB];
              upd_zs   = 1'b1;
              done_d   = 1'b1;
            end
            OP_PUSH: begin
              result_d = registor_in - STACK_STEP;
              done_d   = 1'b1;
            end
            OP_POP: begin
              result_d = registor_in + STACK_STEP;
              done_d   = 1'b1;
            end
            OP_MOV: begin
              result_d = immidiate_data;
              done_d   = 1'b1;
            end
            OP_SHL: begin
              state_d = ITER;
              busy_d  = 1'b1;
            end
            OP_MUL: begin
              state_d = ITER;
              busy_d  = 1'b1;
              cnt_d   = '1;
            end
            default: begin
              done_d    = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end

      ITER: begin
        if (op_q == OP_SHL) begin
          if (cnt_q == '0) begin
            result_d = a_q;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            res   = a_q << 1;
            a_d   = res;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
              result_d = res;
              cf_d     = a_q[MSB];
              of_d     = 1'b0;
              upd_zs   = 1'b1;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
          end
        end else begin
          addend  = prod_q[0] ? a_q : '0;
          ext     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
          prod_nx = {ext, prod_q[WIDTH-1:1]};
          prod_d  = prod_nx;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            res      = prod_nx[WIDTH-1:0];
            result_d = res;
            cf_d     = |prod_nx[2*WIDTH-1:WIDTH];
            of_d     = |prod_nx[2*WIDTH-1:WIDTH];
            upd_zs   = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (upd_zs) begin
      zf_d = (res == '0);
      sf_d = res[MSB];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a WIDTH=32 instance checked against a small
// reference model, plus a WIDTH=16 instance for the stack-step scaling.
module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        ill;
    int          lat;
    int          bsy;
  } exp_t;

  logic        clock_5 = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  ope     = 8'h00;
  logic [31:0] immidiate_data = '0;
  logic [31:0] registor_in    = '0;
  logic        busy, done, illegal, zf, sf, cf, of;
  logic [31:0] alu_result_bus;

  logic        start16 = 1'b0;
  logic [7:0]  ope16   = 8'h00;
  logic [15:0] imm16   = '0;
  logic [15:0] reg16   = '0;
  logic        busy16, done16, illegal16, zf16, sf16, cf16, of16;
  logic [15:0] result16;

  int checks = 0;
  int errors = 0;

  exp_t  sbQ[$];
  string tagQ[$];

  logic [31:0] mRes = '0;
  logic        mZf = 1'b0, mSf = 1'b0, mCf = 1'b0, mOf = 1'b0;

  always #5 clock_5 = ~clock_5;

  alu_seq #(.WIDTH(32)) dut (
    .clock_5(clock_5), .reset(reset), .start(start), .ope(ope),
    .immidiate_data(immidiate_data), .registor_in(registor_in),
    .busy(busy), .done(done), .illegal(illegal), .alu_result_bus(alu_result_bus),
    .zf(zf), .sf(sf), .cf(cf), .of(of)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clock_5(clock_5), .reset(reset), .start(start16), .ope(ope16),
    .immidiate_data(imm16), .registor_in(reg16),
    .busy(busy16), .done(done16), .illegal(illegal16), .alu_result_bus(result16),
    .zf(zf16), .sf(sf16), .cf(cf16), .of(of16)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: updates the architectural state and queues the expectation.
  task automatic modelOp(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t        e;
    logic [63:0] s;
    longint      t;
    logic [31:0] r;
    int          c;
    bit          wz;
    r = mRes; wz = 0;
    e.ill = 1'b0; e.lat = 1; e.bsy = 0;
    case (op)
      8'h01: begin
        s = {32'b0, a} + {32'b0, b}; r = s[31:0]; mRes = r; mCf = s[32];
        t = longint'($signed(a)) + longint'($signed(b));
        mOf = (t > 64'sd2147483647) || (t < -64'sd2147483648); wz = 1;
      end
      8'h29, 8'h39: begin
        r = a - b; if (op == 8'h29) mRes = r; mCf = (a < b);
        t = longint'($signed(a)) - longint'($signed(b));
        mOf = (t > 64'sd2147483647) || (t < -64'sd2147483648); wz = 1;
      end
      8'h21: begin r = a & b; mRes = r; mCf = 0; mOf = 0; wz = 1; end
      8'h09: begin r = a | b; mRes = r; mCf = 0; mOf = 0; wz = 1; end
      8'h31: begin r = a ^ b; mRes = r; mCf = 0; mOf = 0; wz = 1; end
      8'h40: begin r = a + 1; mRes = r; mOf = (a == 32'h7FFFFFFF); wz = 1; end
      8'h48: begin r = a - 1; mRes = r; mOf = (a == 32'h80000000); wz = 1; end
      8'h55: mRes = a - 4;
      8'h5d: mRes = a + 4;
      8'h89: mRes = b;
      8'hd1: begin
        c = int'(b[4:0]);
        if (c == 0) begin
          mRes = a; e.lat = 2; e.bsy = 1;
        end else begin
          r = a << c; mRes = r; mCf = a[32-c]; mOf = 0; wz = 1;
          e.lat = c + 1; e.bsy = c;
        end
      end
      8'hf7: begin
        s = {32'b0, a} * {32'b0, b}; r = s[31:0]; mRes = r;
        mCf = (s[63:32] != 0); mOf = mCf; wz = 1;
        e.lat = 33; e.bsy = 32;
      end
      default: e.ill = 1'b1;
    endcase
    if (wz) begin mZf = (r == 0); mSf = r[31]; end
    e.res = mRes;
    e.flags = {mZf, mSf, mCf, mOf};
    sbQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Drives one request, scrambles inputs after acceptance, optionally pokes a
  // second start at cycle 'poke', then pops the scoreboard when done appears.
  task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int poke);
    exp_t  e;
    string t;
    int    busySeen, lat;
    bit    got;
    modelOp(op, a, b, tag);
    @(negedge clock_5);
    start = 1'b1; ope = op; registor_in = a; immidiate_data = b;
    @(posedge clock_5);
    #1;
    start = 1'b0; ope = 8'($urandom); registor_in = $urandom; immidiate_data = $urandom;
    busySeen = 0; got = 0; lat = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clock_5);
      if (done) begin got = 1; lat = j; break; end
      if (busy) busySeen++;
      if (poke != 0 && j == poke) begin start = 1'b1; ope = 8'h01; end
      else start = 1'b0;
    end
    start = 1'b0;
    checkOutput({tag, "_done_seen"}, 64'(got), 64'd1);
    checkOutput("sb_nonempty", 64'(sbQ.size() != 0), 64'd1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      t = tagQ.pop_front();
      if (got) begin
        checkOutput({t, "_latency"}, 64'(lat), 64'(e.lat));
        checkOutput({t, "_busy_cycles"}, 64'(busySeen), 64'(e.bsy));
        checkOutput({t, "_result"}, 64'(alu_result_bus), 64'(e.res));
        checkOutput({t, "_flags"}, 64'({zf, sf, cf, of}), 64'(e.flags));
        checkOutput({t, "_illegal"}, 64'(illegal), 64'(e.ill));
      end
    end
    @(negedge clock_5);
    checkOutput({tag, "_done_pulse"}, 64'({done, illegal}), 64'd0);
  endtask

  logic [7:0] opsTbl [12] = '{8'h01, 8'h29, 8'h39, 8'h21, 8'h09, 8'h31,
                              8'h40, 8'h48, 8'h55, 8'h5d, 8'h89, 8'hd1};
  int doneCnt;

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clock_5);
    #1;
    checkOutput("reset_outputs", 64'({busy, done, illegal, zf, sf, cf, of}), 64'd0);
    checkOutput("reset_result", 64'(alu_result_bus), 64'd0);
    checkOutput("reset16_outputs", 64'({busy16, done16, illegal16, result16}), 64'd0);
    @(negedge clock_5);
    reset = 1'b0;

    applyStimulus("add_ovf", 8'h01, 32'h7FFFFFFF, 32'h1, 0);
    checkOutput("add_ovf_const", 64'({alu_result_bus, zf, sf, cf, of}), {28'b0, 32'h80000000, 4'b0101});
    applyStimulus("sub_eq", 8'h29, 32'd5, 32'd5, 0);
    applyStimulus("sub_neg", 8'h29, 32'd3, 32'd5, 0);
    applyStimulus("cmp_neg", 8'h39, 32'd3, 32'd5, 0);
    checkOutput("cmp_keeps_result", 64'(alu_result_bus), 64'hFFFFFFFE);
    applyStimulus("push", 8'h55, 32'h100, 32'h0, 0);
    checkOutput("push_const", 64'(alu_result_bus), 64'hFC);
    applyStimulus("pop", 8'h5d, 32'h100, 32'h0, 0);
    applyStimulus("push_wrap", 8'h55, 32'h0, 32'h0, 0);
    checkOutput("push_wrap_const", 64'(alu_result_bus), 64'hFFFFFFFC);
    applyStimulus("inc_ovf", 8'h40, 32'h7FFFFFFF, 32'h0, 0);
    applyStimulus("dec_ovf", 8'h48, 32'h80000000, 32'h0, 0);
    applyStimulus("xor", 8'h31, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
    applyStimulus("mov", 8'h89, 32'h1, 32'hDEADBEEF, 0);
    applyStimulus("mul_big", 8'hf7, 32'h10000, 32'h10000, 5);
    checkOutput("mul_big_const", 64'({alu_result_bus, zf, cf, of}), {29'b0, 32'h0, 3'b111});
    applyStimulus("mul_small", 8'hf7, 32'd7, 32'd6, 0);
    checkOutput("mul_small_const", 64'({alu_result_bus, cf, of}), {30'b0, 32'd42, 2'b00});
    applyStimulus("shl1", 8'hd1, 32'h80000001, 32'd1, 0);
    checkOutput("shl1_const", 64'({alu_result_bus, cf}), {31'b0, 32'h2, 1'b1});
    applyStimulus("shl4", 8'hd1, 32'h12345678, 32'd4, 0);
    applyStimulus("shl0", 8'hd1, 32'hCAFEF00D, 32'h40, 0);
    applyStimulus("illegal", 8'hFF, 32'h1, 32'h2, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus("rand", opsTbl[$urandom_range(0, 11)], $urandom, $urandom, 0);
    end
    applyStimulus("rand_mul", 8'hf7, $urandom, $urandom, 0);

    // Abort a multiply with reset at its tenth cycle.
    @(negedge clock_5);
    start = 1'b1; ope = 8'hf7; registor_in = 32'h10000; immidiate_data = 32'd3;
    @(posedge clock_5);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clock_5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort_outputs", 64'({busy, done, illegal, zf, sf, cf, of}), 64'd0);
    checkOutput("abort_result", 64'(alu_result_bus), 64'd0);
    mRes = '0; mZf = 0; mSf = 0; mCf = 0; mOf = 0;
    @(negedge clock_5);
    reset = 1'b0;
    doneCnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock_5);
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
    applyStimulus("add_after_reset", 8'h01, 32'd2, 32'd3, 0);

    // Stack step scales with the data width.
    @(negedge clock_5);
    start16 = 1'b1; ope16 = 8'h55; reg16 = 16'h0100;
    @(posedge clock_5);
    #1;
    start16 = 1'b0;
    @(negedge clock_5);
    checkOutput("push16", 64'({done16, result16, zf16, sf16, cf16, of16}), {43'b0, 1'b1, 16'h00FE, 4'b0});
    @(negedge clock_5);
    start16 = 1'b1; ope16 = 8'h5d; reg16 = 16'h0100;
    @(posedge clock_5);
    #1;
    start16 = 1'b0;
    @(negedge clock_5);
    checkOutput("pop16", 64'({done16, result16}), {47'b0, 1'b1, 16'h0102});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the single-cycle opcode ALU in the execute stage.
- Accepts an x86-style 8-bit opcode with a register operand and an immediate operand, then produces a registered result plus ZF/SF/CF/OF flags.
- Runs single-cycle ops in one clock, and runs shift and multiply iteratively under a start/busy/done handshake.
- The stack-pointer adjust for push/pop scales with the data width.

Parameters:
WIDTH, 32, datapath width in bits; power of two, 8..64
SHW, $clog2(WIDTH), shift-count bits taken from immidiate_data

Ports:
clock_5  input  1  execute-phase clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
ope  input  8  opcode
immidiate_data  input  WIDTH  operand B
registor_in  input  WIDTH  operand A
busy  output  1  high while an iterative op runs
done  output  1  one-cycle pulse when the result/flags are updated
illegal  output  1  one-cycle pulse with done for an unknown opcode
alu_result_bus  output  WIDTH  registered result
zf, sf, cf, of  output  1 each  registered flags

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, all outputs 0, internal operand/accumulator registers 0.
  - Reset asserted mid-operation aborts it; no done is issued.
- States: IDLE, ITER.
  - IDLE & start: latch ope, A=registor_in, B=immidiate_data. Input changes after this edge are ignored until the next accepted start.
  - start while busy=1 is ignored; it is not queued.
- Single-cycle ops, accepted at edge k: result and flags are written at edge k; done=1 for the cycle after edge k; state stays IDLE.
  - 0x01 add: A+B.
  - 0x29 sub: A-B.
  - 0x39 cmp: A-B; flags only, result unchanged.
  - 0x21 and, 0x09 or, 0x31 xor.
  - 0x40 inc: A+1.
  - 0x48 dec: A-1.
  - 0x55 push: A-WIDTH/8.
  - 0x5d pop: A+WIDTH/8.
  - 0x89 mov: B.
- Iterative ops, accepted at edge k: go to ITER and set busy=1.
  - 0xd1 shl: A << B[SHW-1:0], one bit per cycle.
    - N = max(count,1).
    - Count 0 gives result=A with flags unchanged.
    - cf = last bit shifted out; of=0; zf/sf from result.
  - 0xf7 mul: unsigned shift-add, N=WIDTH cycles.
    - Result = low WIDTH bits of the 2*WIDTH product.
    - cf = of = (high half != 0).
    - zf/sf from the low half.
  - At edge k+N: result and flags written, busy=0, done pulse, return to IDLE.
  - A new start may be accepted in the cycle done is high.
- Flags (all arithmetic is modulo 2^WIDTH):
  - zf = (result==0) and sf = result[WIDTH-1], for every flag-writing op.
  - add: cf = carry-out; of = signed overflow.
  - sub/cmp: cf = borrow (A<B unsigned); of = signed overflow.
  - and/or/xor: cf=0, of=0.
  - inc/dec: cf preserved; of = signed overflow (0x7F..F+1, 0x80..0-1).
  - push/pop/mov: all flags unchanged.
- Unknown opcode:
  - Completes in one cycle with done=1 and illegal=1.
  - Result and flags unchanged.
- Push/pop wrap modulo 2^WIDTH, e.g. push with A=0 gives 2^WIDTH-WIDTH/8.
- done and illegal are never high for more than one consecutive cycle per operation.

Test Plan:
- Add overflow (WIDTH=32): add A=0x7FFFFFFF, B=1.
  - Result 0x80000000, of=1, sf=1, cf=0, zf=0.
  - done high exactly one cycle after the start edge; busy stays 0.
- Subtract and compare:
  - sub A=5, B=5 -> result 0, zf=1, cf=0.
  - sub A=3, B=5 -> result 0xFFFFFFFE, cf=1, sf=1.
  - cmp A=3, B=5 -> same flags, result stays 0xFFFFFFFE.
- Stack adjust:
  - push A=0x100 -> 0xFC.
  - pop A=0x100 -> 0x104.
  - push A=0 -> 0xFFFFFFFC.
  - Flags unchanged in all three cases.
  - Repeat at WIDTH=16: push A=0x100 -> 0xFE.
- Multiply: mul A=0x10000, B=0x10000.
  - busy high for 32 cycles, then result 0, cf=of=1, zf=1.
  - A second start pulsed mid-op is ignored.
  - mul 7*6 -> 42, cf=of=0.
- Shift:
  - shl A=0x80000001, count 1 -> 0x00000002, cf=1, latency 1.
  - count 4 -> busy 4 cycles.
  - count 0 -> result=A, flags unchanged.
- Reset and illegal opcode:
  - Assert reset at cycle 10 of a mul -> all outputs 0 immediately, no done, and the next add works normally.
  - ope=0xFF -> done=1 and illegal=1 for one cycle, result unchanged.
